// File: rtl/mult_div_unit_if.sv
// Command/result bundle between the CPU control unit and mult_div_unit.
// Master is the control unit side; slave is the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b, hi_wr, lo_wr, wr_data,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b, hi_wr, lo_wr, wr_data,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiply / restoring divide with HI/LO registers, one bit per cycle.
// Define MDU_UNSIGNED_EN to build the MULTU/DIVU operand path; otherwise op[1] is ignored.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]         state_q;
  logic [CntW-1:0]    cnt_q;
  // Mul: {partial product, multiplier}; div: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q, neg_q, neg_rem_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, div_zero_q;

  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MDU_UNSIGNED_EN
  assign is_signed = ~bus.op[1];
`else
  logic unused_op_hi;
  assign unused_op_hi = bus.op[1];
  assign is_signed    = 1'b1;
`endif

  always_comb begin
    a_neg     = is_signed & bus.a[WIDTH-1];
    b_neg     = is_signed & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.hi_wr) hi_q <= bus.wr_data;
          if (bus.lo_wr) lo_q <= bus.wr_data;
          if (bus.start) begin
            cnt_q     <= '0;
            is_div_q  <= bus.op[0];
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (bus.op[0]) begin
              acc_q  <= {{WIDTH{1'b0}}, a_mag};
              opnd_q <= b_mag;
              dz_q   <= (bus.b == '0);
              state_q <= (bus.b == '0) ? StDone : StDiv;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, b_mag};
              opnd_q  <= a_mag;
              dz_q    <= 1'b0;
              state_q <= StMul;
            end
          end
        end
        StMul: begin
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) state_q <= StDone;
        end
        StDiv: begin
          // Restoring step: keep the trial difference only when it did not borrow.
          if (!div_diff[WIDTH]) begin
            acc_q <= {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_q <= {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) state_q <= StDone;
        end
        default: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
          if (dz_q) begin
            div_zero_q <= 1'b1;
          end else if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
      endcase
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit (WIDTH=32): driver queues expected HI/LO/flag/latency,
// a negedge monitor checks them whenever done pulses.
module tb_mult_div_unit;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MDU_UNSIGNED_EN
  localparam logic [31:0] MuFfHi  = 32'hFFFFFFFE;
  localparam logic [31:0] DuLo    = 32'h55555554;
  localparam logic [31:0] DuHi    = 32'h00000002;
  localparam logic [31:0] Mu2Hi   = 32'h00000001;
`else
  localparam logic [31:0] MuFfHi  = 32'h00000000;
  localparam logic [31:0] DuLo    = 32'h00000000;
  localparam logic [31:0] DuHi    = 32'hFFFFFFFE;
  localparam logic [31:0] Mu2Hi   = 32'hFFFFFFFF;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected done", 64'(bus.done), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, " hi"}, 64'(bus.hi), 64'(e.hi));
          chk({e.name, " lo"}, 64'(bus.lo), 64'(e.lo));
          chk({e.name, " div_zero"}, 64'(bus.div_zero), 64'(e.dz));
          chk({e.name, " latency"}, 64'(cyc - e.start_cyc), 64'(e.lat));
          chk({e.name, " busy at done"}, 64'(bus.busy), 64'(0));
        end
      end else if (bus.div_zero) begin
        chk("div_zero without done", 64'(bus.div_zero), 64'(0));
      end
    end
  end

  // Called at a negedge; poke 1 = stray start mid-op, 2 = hi/lo write while busy.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int poke);
    exp_t e;
    e.name = name; e.hi = ehi; e.lo = elo; e.dz = edz;
    e.lat = edz ? 1 : 33;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = ~op; bus.a = 32'h13579BDF; bus.b = 32'h0;
    chk({name, " busy after start"}, 64'(bus.busy), 64'(1));
    if (poke == 2) begin
      bus.hi_wr = 1'b1; bus.lo_wr = 1'b1; bus.wr_data = 32'hBAD0BAD0;
      @(negedge clk);
      bus.hi_wr = 1'b0; bus.lo_wr = 1'b0;
    end
    if (poke == 1) begin
      repeat (4) @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
    if (bus.busy) chk({name, " timeout busy"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_wr = 1'b0; bus.lo_wr = 1'b0; bus.wr_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset hi", 64'(bus.hi), 64'(0));
    chk("reset lo", 64'(bus.lo), 64'(0));
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset done", 64'(bus.done), 64'(0));
    chk("reset div_zero", 64'(bus.div_zero), 64'(0));

    run_op("mult 7*-3", 2'b00, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
    run_op("div -7/2", 2'b01, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    run_op("div min/-1", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 0);
    run_op("div 7/-2", 2'b01, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 0);

    // Preload HI/LO at idle, then a divide by zero must leave them untouched.
    bus.hi_wr = 1'b1; bus.lo_wr = 1'b0; bus.wr_data = 32'h11;
    @(negedge clk);
    bus.hi_wr = 1'b0; bus.lo_wr = 1'b1; bus.wr_data = 32'h22;
    @(negedge clk);
    bus.lo_wr = 1'b0;
    chk("mthi", 64'(bus.hi), 64'h11);
    chk("mtlo", 64'(bus.lo), 64'h22);
    run_op("div 5/0", 2'b01, 32'h5, 32'h0, 32'h11, 32'h22, 1'b1, 2);

    run_op("multu ff*ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, MuFfHi, 32'h1, 1'b0, 0);
    run_op("divu fffffffe/3", 2'b11, 32'hFFFFFFFE, 32'h3, DuHi, DuLo, 1'b0, 0);
    run_op("mult min*min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 1);
    run_op("mult 2^16*2^16", 2'b00, 32'h10000, 32'h10000, 32'h1, 32'h0, 1'b0, 0);
    run_op("multu min*2", 2'b10, 32'h80000000, 32'h2, Mu2Hi, 32'h0, 1'b0, 0);

    // Async reset mid-op: state clears immediately and no done may follow.
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h3; bus.b = 32'h5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midop reset busy", 64'(bus.busy), 64'(0));
    chk("midop reset hi", 64'(bus.hi), 64'(0));
    chk("midop reset lo", 64'(bus.lo), 64'(0));
    chk("midop reset done", 64'(bus.done), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    chk("scoreboard drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
